// File: rtl/common.sv
// Shared fetch-stage types: word aliases, fetch sequencer states and the reset PC.
package common;

    typedef logic [63:0] u64;
    typedef logic [31:0] u32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DROP
    } fetch_state_t;

    localparam u64 RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

endpackage

// File: rtl/fetch_pc.sv
// Architectural fetch PC and instruction-fetch sequencer: one bus transaction at a
// time, one instruction presented to decode per fetch, stale fetches dropped on redirect.
module fetch_pc
    import common::*;
#(
    parameter u64 RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [63:0] pc_selected,
    output logic [63:0] pcplus4,
    input  logic        redirect,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_addr_ok,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    output logic        f_valid,
    output logic [63:0] f_pc,
    output logic [31:0] f_instr,
    output logic        f_exc,
    input  logic        d_ready
);

    fetch_state_t state, state_n;
    u64           pc, pc_n;
    u64           req_addr, req_addr_n;
    logic         stale, stale_n;
    u64           f_pc_q, f_pc_n;
    u32           f_instr_q, f_instr_n;
    logic         f_exc_q, f_exc_n;
    logic         do_launch;
    u64           launch_pc;

    assign pcplus4    = pc + 64'd4;
    assign ireq_valid = (state == S_REQ);
    // ireq_addr comes from its own register so a redirect cannot disturb a pending request
    assign ireq_addr  = req_addr;
    assign f_valid    = (state == S_HOLD);
    assign f_pc       = f_pc_q;
    assign f_instr    = f_instr_q;
    assign f_exc      = f_exc_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            pc        <= RESET_PC;
            req_addr  <= RESET_PC;
            stale     <= 1'b0;
            f_pc_q    <= RESET_PC;
            f_instr_q <= '0;
            f_exc_q   <= 1'b0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            req_addr  <= req_addr_n;
            stale     <= stale_n;
            f_pc_q    <= f_pc_n;
            f_instr_q <= f_instr_n;
            f_exc_q   <= f_exc_n;
        end
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        req_addr_n = req_addr;
        stale_n    = stale;
        f_pc_n     = f_pc_q;
        f_instr_n  = f_instr_q;
        f_exc_n    = f_exc_q;
        do_launch  = 1'b0;
        launch_pc  = redirect ? pc_selected : pc;

        if (redirect)
            pc_n = pc_selected;

        case (state)
            S_IDLE: do_launch = 1'b1;
            S_REQ: begin
                if (iresp_addr_ok) begin
                    if (stale || redirect) begin
                        if (iresp_data_ok)
                            do_launch = 1'b1;
                        else
                            state_n = S_DROP;
                    end else if (iresp_data_ok) begin
                        state_n   = S_HOLD;
                        f_pc_n    = req_addr;
                        f_instr_n = iresp_data;
                        f_exc_n   = 1'b0;
                    end else begin
                        state_n = S_WAIT;
                    end
                end else if (redirect) begin
                    stale_n = 1'b1;
                end
            end
            S_WAIT: begin
                // data arriving with the redirect is already stale; drop it and relaunch
                if (iresp_data_ok) begin
                    if (redirect) begin
                        do_launch = 1'b1;
                    end else begin
                        state_n   = S_HOLD;
                        f_pc_n    = req_addr;
                        f_instr_n = iresp_data;
                        f_exc_n   = 1'b0;
                    end
                end else if (redirect) begin
                    state_n = S_DROP;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    do_launch = 1'b1;
                end else if (d_ready) begin
                    pc_n      = pc_selected;
                    launch_pc = pc_selected;
                    do_launch = 1'b1;
                end
            end
            S_DROP: begin
                if (iresp_data_ok)
                    do_launch = 1'b1;
            end
            default: state_n = S_IDLE;
        endcase

        if (do_launch) begin
            stale_n = 1'b0;
            if (launch_pc[1:0] != 2'b00) begin
                state_n   = S_HOLD;
                f_exc_n   = 1'b1;
                f_pc_n    = launch_pc;
                f_instr_n = '0;
            end else begin
                state_n    = S_REQ;
                req_addr_n = launch_pc;
            end
        end
    end

endmodule
